// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared IEEE-754 single-precision multiplier.
// Optional abort-on-timeout in BUSY is enabled with macro FPMUL_ARB_TIMEOUT_EN.
module fpmul_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_p,
  output logic [5:0]  rsp0_flags,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_p,
  output logic [5:0]  rsp1_flags,
  output logic        rsp1_err,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_rst,
  input  logic        mul_done,
  input  logic [31:0] mul_p,
  input  logic [5:0]  mul_flags,
  output logic        busy
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("fpmul_arbiter: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t      state;
  logic        last;
  logic        gid;
  logic        issue_second;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        any_req;
  logic        pick;
  logic        expire;
  logic        capture;
  logic [31:0] res_p;
  logic [5:0]  res_flags;

  // With both requesting, the one not granted last wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick    = 1'b0;
    if (req0_valid && req1_valid) pick = ~last;
    else                          pick = req1_valid;
  end

  assign req0_ready = !rst && (state == IDLE) && any_req && !pick;
  assign req1_ready = !rst && (state == IDLE) && any_req &&  pick;
  assign busy       = (state != IDLE);
  assign mul_start  = (state == ISSUE);
  assign mul_a      = (state == IDLE) ? 32'h0 : op_a;
  assign mul_b      = (state == IDLE) ? 32'h0 : op_b;
  assign rsp0_valid = (state == RESP) && !gid;
  assign rsp1_valid = (state == RESP) &&  gid;

  assign capture   = (state == BUSY) && (mul_done || expire);
  assign res_p     = expire ? 32'h7FC0_0000 : mul_p;
  assign res_flags = expire ? 6'b000100     : mul_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      gid          <= 1'b0;
      issue_second <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      rsp0_p       <= '0;
      rsp0_flags   <= '0;
      rsp1_p       <= '0;
      rsp1_flags   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gid          <= pick;
            last         <= pick;
            op_a         <= pick ? req1_a : req0_a;
            op_b         <= pick ? req1_b : req0_b;
            issue_second <= 1'b0;
            state        <= ISSUE;
          end
        end
        // Two start cycles cover the multiplier's reset-then-wait window.
        ISSUE: begin
          if (issue_second) state <= BUSY;
          issue_second <= 1'b1;
        end
        BUSY: begin
          if (capture) begin
            if (gid) begin
              rsp1_p     <= res_p;
              rsp1_flags <= res_flags;
            end else begin
              rsp0_p     <= res_p;
              rsp0_flags <= res_flags;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;
  logic             abort;

  assign expire  = (state == BUSY) && !mul_done && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign mul_rst = rst | abort;

  // Counter sits at zero outside BUSY, so it is clear on every BUSY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      abort    <= 1'b0;
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      cnt   <= (state == BUSY) ? cnt + 1'b1 : '0;
      abort <= capture && expire;
      if (capture && !gid) rsp0_err <= expire;
      if (capture &&  gid) rsp1_err <= expire;
    end
  end
`else
  assign expire   = 1'b0;
  assign mul_rst  = rst;
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter; the bench itself plays the shared multiplier.
module tb_fpmul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_p, rsp1_p;
  logic [5:0]  rsp0_flags, rsp1_flags;
  logic        mul_start, mul_rst, mul_done, busy;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [5:0]  mul_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpmul_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst),
    .mul_done(mul_done), .mul_p(mul_p), .mul_flags(mul_flags),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with requests already driven; leaves the DUT in the first ISSUE cycle.
  task automatic grant(input int id, input logic [31:0] ea, input logic [31:0] eb);
    #1;
    chk("ready0", {31'b0, req0_ready}, (id == 0) ? 32'd1 : 32'd0);
    chk("ready1", {31'b0, req1_ready}, (id == 1) ? 32'd1 : 32'd0);
    tick();
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    chk("ready_busy", {30'b0, req0_ready, req1_ready}, 32'd0);
  endtask

  // From the first ISSUE cycle through RESP and back to IDLE, returning p/flags as the multiplier.
  task automatic finish_op(input int id, input logic [31:0] p, input logic [5:0] f);
    chk("start_c1", {31'b0, mul_start}, 32'd1);
    tick();
    chk("start_c2", {31'b0, mul_start}, 32'd1);
    tick();
    chk("start_off", {31'b0, mul_start}, 32'd0);
    chk("busy_on", {31'b0, busy}, 32'd1);
    tick();
    chk("no_early_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    mul_done = 1'b1; mul_p = p; mul_flags = f;
    tick();
    mul_done = 1'b0; mul_p = '0; mul_flags = '0;
    chk("rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, (id == 1) ? 32'd2 : 32'd1);
    chk("rsp_p", (id == 1) ? rsp1_p : rsp0_p, p);
    chk("rsp_flags", {26'b0, (id == 1) ? rsp1_flags : rsp0_flags}, {26'b0, f});
    chk("rsp_err", {31'b0, (id == 1) ? rsp1_err : rsp0_err}, 32'd0);
    tick();
    chk("rsp_drop", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("busy_off", {31'b0, busy}, 32'd0);
    chk("mul_a_idle", mul_a, 32'd0);
    chk("rsp_hold", (id == 1) ? rsp1_p : rsp0_p, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    mul_done = 1'b0; mul_p = '0; mul_flags = '0;
    tick();
    chk("mul_rst_in_rst", {31'b0, mul_rst}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mul_rst", {31'b0, mul_rst}, 32'd0);
    chk("rst_rsp0_p", rsp0_p, 32'd0);
    chk("rst_rsp1_flags", {26'b0, rsp1_flags}, 32'd0);
    chk("rst_outs", {25'b0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mul_start}, 32'd0);

    // Tie after reset: requester 0 first, then requester 1.
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
    req1_valid = 1'b1; req1_a = 32'h4040_0000; req1_b = 32'h4080_0000;
    grant(0, 32'h3F80_0000, 32'h4000_0000);
    req0_valid = 1'b0;
    finish_op(0, 32'h4000_0000, 6'b0);
    grant(1, 32'h4040_0000, 32'h4080_0000);
    req1_valid = 1'b0;
    finish_op(1, 32'h4140_0000, 6'b0);

    // Both held valid: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
    req1_valid = 1'b1; req1_a = 32'h3F00_0000; req1_b = 32'h4000_0000;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        grant(0, 32'h4000_0000, 32'h4000_0000);
        finish_op(0, 32'h4080_0000, 6'b0);
      end else begin
        grant(1, 32'h3F00_0000, 32'h4000_0000);
        finish_op(1, 32'h3F80_0000, 6'b0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 2.0 * 3.0 = 6.0 on requester 0.
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
    grant(0, 32'h4000_0000, 32'h4040_0000);
    req0_valid = 1'b0;
    finish_op(0, 32'h40C0_0000, 6'b0);

    // NaN * 1.0 on requester 1 alone.
    req1_valid = 1'b1; req1_a = 32'h7FC0_0000; req1_b = 32'h3F80_0000;
    grant(1, 32'h7FC0_0000, 32'h3F80_0000);
    req1_valid = 1'b0;
    finish_op(1, 32'h7FC0_0000, 6'b000100);
    chk("nan_exp", {24'b0, rsp1_p[30:23]}, 32'hFF);
    chk("nan_flag", {31'b0, rsp1_flags[2]}, 32'd1);

    // Stray mul_done in IDLE is ignored.
    mul_done = 1'b1; mul_p = 32'h1234_5678;
    tick();
    mul_done = 1'b0; mul_p = '0;
    chk("stray_busy", {31'b0, busy}, 32'd0);
    chk("stray_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("stray_p", rsp0_p, 32'h40C0_0000);

    // Reset while BUSY drops the operation silently.
    req0_valid = 1'b1; req0_a = 32'h4080_0000; req0_b = 32'h4080_0000;
    grant(0, 32'h4080_0000, 32'h4080_0000);
    req0_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mul_rst_busy", {31'b0, mul_rst}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("post_rst_p", rsp0_p, 32'd0);
    mul_done = 1'b1; mul_p = 32'h4180_0000;
    tick();
    mul_done = 1'b0; mul_p = '0;
    chk("post_rst_done", {29'b0, busy, rsp0_valid, rsp1_valid}, 32'd0);
    req0_valid = 1'b1; req0_a = 32'h4080_0000; req0_b = 32'h4080_0000;
    grant(0, 32'h4080_0000, 32'h4080_0000);
    req0_valid = 1'b0;
    finish_op(0, 32'h4180_0000, 6'b0);

`ifdef FPMUL_ARB_TIMEOUT_EN
    // Multiplier never answers: abort after 16 BUSY cycles.
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
    grant(0, 32'h4000_0000, 32'h4000_0000);
    req0_valid = 1'b0;
    tick();
    tick();
    chk("tmo_busy0", {31'b0, busy}, 32'd1);
    repeat (15) tick();
    chk("tmo_wait", {30'b0, rsp0_valid, mul_rst}, 32'd0);
    tick();
    chk("tmo_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("tmo_mul_rst", {31'b0, mul_rst}, 32'd1);
    chk("tmo_err", {31'b0, rsp0_err}, 32'd1);
    chk("tmo_p", rsp0_p, 32'h7FC0_0000);
    chk("tmo_flags", {26'b0, rsp0_flags}, 32'd4);
    tick();
    chk("tmo_end", {30'b0, busy, mul_rst}, 32'd0);
    chk("tmo_err_hold", {31'b0, rsp0_err}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
